// File: rtl/ddr_app_burst_arbiter.sv
// Purpose: shares one DDR app port between a write burst requester and a read burst requester (round-robin).
// Latency: grant and first app command one cycle after the request is seen in IDLE; one command per app_rdy.
// Backpressure: app_rdy stalls command issue, app_wdf_rdy stalls write beats, read grants wait on outstanding budget.
module ddr_app_burst_arbiter #(
  parameter int ADDR_WIDTH   = 27,
  parameter int DATA_WIDTH   = 256,
  parameter int ADDR_STEP    = 8,
  parameter int MAX_RD_OUTST = 64
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    init_calib_complete,
  // write burst requester
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [7:0]              wr_len,
  output logic                    wr_gnt,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_dvalid,
  output logic                    wr_dready,
  output logic                    wr_done,
  // read burst requester
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [7:0]              rd_len,
  output logic                    rd_gnt,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_dvalid,
  output logic                    rd_err,
  // DDR controller app port
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid
);

  // Outstanding counter holds 0..MAX_RD_OUTST; the eligibility sum needs room
  // for a full 256-beat burst on top of that.
  localparam int OUTST_W = $clog2(MAX_RD_OUTST + 1);
  localparam int SUM_W   = $clog2(MAX_RD_OUTST + 257) + 1;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_IDLE  = 3'b111;

  typedef enum logic [2:0] {
    S_NOP,
    S_IDLE,
    S_WR_CMD,
    S_RD_CMD,
    S_WR_DATA
  } state_t;

  state_t state;
  state_t state_next;

  // Burst context latched at grant time
  logic [7:0]         len_q;
  logic [8:0]         cmd_cnt;
  logic [8:0]         data_cnt;
  logic               last_gnt_rd;   // 1: previous grant went to the reader
  logic [OUTST_W-1:0] outst;

  // Handshake and arbitration terms
  logic               cmd_fire;
  logic               cmd_last;
  logic               rd_cmd_fire;
  logic               data_fire;
  logic [8:0]         len_plus1;
  logic [8:0]         data_cnt_inc;
  logic               wr_data_done;
  logic [SUM_W-1:0]   rd_need;
  logic               rd_elig;
  logic               wr_elig;
  logic               pick_wr;
  logic               pick_rd;
  logic               grant_wr;
  logic               grant_rd;

  // Pass-through channels
  assign rd_data      = app_rd_data;
  assign rd_dvalid    = app_rd_data_valid;
  assign app_wdf_data = wr_data;
  assign app_wdf_wren = data_fire;
  assign app_wdf_end  = 1'b1;
  assign app_wdf_mask = '0;

  assign cmd_fire     = app_en && app_rdy;
  assign cmd_last     = cmd_fire && (cmd_cnt == {1'b0, len_q});
  assign rd_cmd_fire  = cmd_fire && (state == S_RD_CMD);
  assign data_fire    = wr_dvalid && wr_dready;
  assign len_plus1    = {1'b0, len_q} + 9'd1;
  // A beat accepted this very cycle counts toward completion
  assign data_cnt_inc = data_cnt + {8'd0, data_fire};
  assign wr_data_done = (data_cnt_inc == len_plus1);

  // Read bursts are only granted when all their beats fit in the return budget
  assign rd_need = SUM_W'(outst) + SUM_W'(rd_len) + SUM_W'(1);
  assign rd_elig = rd_req && (rd_need <= SUM_W'(MAX_RD_OUTST));
  assign wr_elig = wr_req;

  // Round-robin pick: on a tie the side that did not win last time goes first
  always_comb begin
    pick_wr = 1'b0;
    pick_rd = 1'b0;
    if (wr_elig && rd_elig) begin
      pick_wr = last_gnt_rd;
      pick_rd = !last_gnt_rd;
    end else begin
      pick_wr = wr_elig;
      pick_rd = rd_elig;
    end
  end

  // Grants are only issued from IDLE while calibration is still reported good
  assign grant_wr = (state == S_IDLE) && init_calib_complete && pick_wr;
  assign grant_rd = (state == S_IDLE) && init_calib_complete && pick_rd;

  // Completion pulse coincides with the final command or final data beat
  assign wr_done = ((state == S_WR_CMD)  && cmd_last  && wr_data_done) ||
                   ((state == S_WR_DATA) && data_fire && wr_data_done);

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_NOP;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; calibration is only watched between bursts
  always_comb begin
    state_next = state;
    case (state)
      S_NOP: begin
        if (init_calib_complete) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!init_calib_complete) begin
          state_next = S_NOP;
        end else if (grant_wr) begin
          state_next = S_WR_CMD;
        end else if (grant_rd) begin
          state_next = S_RD_CMD;
        end
      end
      S_WR_CMD: begin
        if (cmd_last) begin
          state_next = wr_data_done ? S_IDLE : S_WR_DATA;
        end
      end
      S_RD_CMD: begin
        if (cmd_last) begin
          state_next = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (data_fire && wr_data_done) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_NOP;
      end
    endcase
  end

  // Moore outputs: command valid/opcode and write-beat acceptance window
  always_comb begin
    app_en    = 1'b0;
    app_cmd   = CMD_IDLE;
    wr_dready = 1'b0;
    case (state)
      S_WR_CMD: begin
        app_en    = 1'b1;
        app_cmd   = CMD_WRITE;
        wr_dready = app_wdf_rdy && (data_cnt <= {1'b0, len_q});
      end
      S_RD_CMD: begin
        app_en  = 1'b1;
        app_cmd = CMD_READ;
      end
      S_WR_DATA: begin
        wr_dready = app_wdf_rdy && (data_cnt <= {1'b0, len_q});
      end
      default: begin
        app_en    = 1'b0;
        app_cmd   = CMD_IDLE;
        wr_dready = 1'b0;
      end
    endcase
  end

  // Grant pulses, burst context capture and address stepping
  always_ff @(posedge clock) begin
    if (rst) begin
      wr_gnt      <= 1'b0;
      rd_gnt      <= 1'b0;
      app_addr    <= '0;
      len_q       <= '0;
      last_gnt_rd <= 1'b1;
    end else begin
      wr_gnt <= grant_wr;
      rd_gnt <= grant_rd;
      if (grant_wr) begin
        app_addr    <= wr_addr;
        len_q       <= wr_len;
        last_gnt_rd <= 1'b0;
      end else if (grant_rd) begin
        app_addr    <= rd_addr;
        len_q       <= rd_len;
        last_gnt_rd <= 1'b1;
      end else if (cmd_fire) begin
        // Address wraps silently at the top of the app address space
        app_addr <= app_addr + ADDR_WIDTH'(ADDR_STEP);
      end
    end
  end

  // Per-burst command and data beat counters
  always_ff @(posedge clock) begin
    if (rst) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else if (grant_wr || grant_rd) begin
      cmd_cnt  <= '0;
      data_cnt <= '0;
    end else begin
      if (cmd_fire) begin
        cmd_cnt <= cmd_cnt + 9'd1;
      end
      if (data_fire) begin
        data_cnt <= data_cnt + 9'd1;
      end
    end
  end

  // Outstanding read beats; an unexpected return at zero is flagged sticky
  always_ff @(posedge clock) begin
    if (rst) begin
      outst  <= '0;
      rd_err <= 1'b0;
    end else begin
      case ({rd_cmd_fire, app_rd_data_valid})
        2'b10: begin
          outst <= outst + OUTST_W'(1);
        end
        2'b01: begin
          if (outst == '0) begin
            rd_err <= 1'b1;
          end else begin
            outst <= outst - OUTST_W'(1);
          end
        end
        default: begin
          outst <= outst;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_app_burst_arbiter.sv
// Purpose: directed self-checking bench for ddr_app_burst_arbiter.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: app_rdy / app_wdf_rdy / wr_dvalid patterns are driven per test.
module tb_ddr_app_burst_arbiter;
  localparam int AW = 27;
  localparam int DW = 256;

  logic            clock = 1'b0;
  logic            rst;
  logic            init_calib_complete;
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic [7:0]      wr_len;
  logic            wr_gnt;
  logic [DW-1:0]   wr_data;
  logic            wr_dvalid;
  logic            wr_dready;
  logic            wr_done;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic [7:0]      rd_len;
  logic            rd_gnt;
  logic [DW-1:0]   rd_data;
  logic            rd_dvalid;
  logic            rd_err;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en;
  logic            app_rdy;
  logic [DW-1:0]   app_wdf_data;
  logic            app_wdf_wren;
  logic            app_wdf_end;
  logic [DW/8-1:0] app_wdf_mask;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;

  always #5 clock = ~clock;

  ddr_app_burst_arbiter dut (
    .clock(clock), .rst(rst), .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .wr_data(wr_data), .wr_dvalid(wr_dvalid), .wr_dready(wr_dready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_dvalid(rd_dvalid), .rd_err(rd_err),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed app-port activity, recorded on the falling edge
  logic [AW-1:0] cmd_addr_q[$];
  logic [2:0]    cmd_op_q[$];
  int wren_n  = 0;
  int done_n  = 0;
  int wrgnt_n = 0;
  int rdgnt_n = 0;

  always @(negedge clock) begin
    if (app_en && app_rdy && !rst) begin
      cmd_addr_q.push_back(app_addr);
      cmd_op_q.push_back(app_cmd);
    end
    if (app_wdf_wren) wren_n++;
    if (wr_done) done_n++;
    if (wr_gnt) wrgnt_n++;
    if (rd_gnt) rdgnt_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; init_calib_complete = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_dvalid = 1'b0; app_rd_data_valid = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (2) tick();
    rst = 1'b0; init_calib_complete = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_gnt(input bit is_rd, input int max, input string tag);
    int n;
    n = 0;
    while (((is_rd ? rd_gnt : wr_gnt) !== 1'b1) && n < max) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, (is_rd ? rd_gnt : wr_gnt)}, 64'd1);
  endtask

  function automatic logic [63:0] cmd_word(input int idx);
    if (idx < cmd_addr_q.size()) return {32'd0, 2'd0, cmd_op_q[idx], cmd_addr_q[idx]};
    return '1;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cmd, base_done, base_wren, base_rg, base_wg, n;
    int ord[$];
    logic          prev_en;
    logic [AW-1:0] prev_addr;
    logic          rdy_used;
    int            hold_bad;

    rst = 1'b1; init_calib_complete = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_len = '0; wr_data = '0; wr_dvalid = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_app_en", {63'd0, app_en}, 64'd0);
    chk("rst_app_cmd", {61'd0, app_cmd}, 64'd7);
    chk("rst_app_addr", {37'd0, app_addr}, 64'd0);
    chk("rst_gnt", {62'd0, wr_gnt, rd_gnt}, 64'd0);
    chk("rst_done_dready_err", {61'd0, wr_done, wr_dready, rd_err}, 64'd0);
    chk("rst_wdf_end_mask", {31'd0, app_wdf_end, app_wdf_mask}, {31'd0, 1'b1, 32'd0});

    // Calibration not done: request must wait in NOP
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = 27'h100; wr_len = 8'd3;
    repeat (4) tick();
    chk("nop_no_gnt", 64'(wrgnt_n), 64'd0);
    chk("nop_app_en", {63'd0, app_en}, 64'd0);

    // Test 1: lone write burst, 4 beats, data alongside commands
    base_cmd = cmd_addr_q.size(); base_done = done_n; base_wren = wren_n;
    wr_dvalid = 1'b1; wr_data = '0; wr_data[63:0] = 64'h1234;
    init_calib_complete = 1'b1;
    wait_gnt(1'b0, 10, "t1_gnt");
    chk("t1_first_cmd", {32'd0, 1'b1, app_cmd, 1'b0, app_addr}, {32'd0, 1'b1, 3'd0, 1'b0, 27'h100});
    chk("t1_wdf_data", app_wdf_data[63:0], 64'h1234);
    wr_req = 1'b0;
    n = 0;
    while (done_n == base_done && n < 20) begin tick(); n++; end
    wr_dvalid = 1'b0;
    repeat (3) tick();
    chk("t1_ncmd", 64'(cmd_addr_q.size() - base_cmd), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_cmd%0d", i), cmd_word(base_cmd + i), {32'd0, 2'd0, 3'd0, 27'(27'h100 + 8 * i)});
    chk("t1_wren", 64'(wren_n - base_wren), 64'd4);
    chk("t1_done", 64'(done_n - base_done), 64'd1);
    chk("t1_idle_cmd", {60'd0, app_en, app_cmd}, 64'd7);

    // Test 2: simultaneous requests, round-robin W, R, W
    do_reset();
    wr_addr = 27'h300; wr_len = 8'd0; rd_addr = 27'h200; rd_len = 8'd0;
    wr_dvalid = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    while (ord.size() < 3 && n < 60) begin
      tick();
      n++;
      if (wr_gnt) ord.push_back(0);
      if (rd_gnt) begin
        ord.push_back(1);
        chk("t2_rd_cmd", {34'd0, app_cmd, app_addr}, {34'd0, 3'd1, 27'h200});
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (6) tick();
    wr_dvalid = 1'b0;
    chk("t2_ngnt", 64'(ord.size()), 64'd3);
    chk("t2_order", {61'd0, 1'(ord.size() > 0 ? ord[0] : 1), 1'(ord.size() > 1 ? ord[1] : 0),
                     1'(ord.size() > 2 ? ord[2] : 1)}, 64'b010);

    // Test 3: read burst under app_rdy toggling 1010...
    do_reset();
    base_cmd = cmd_addr_q.size(); base_rg = rdgnt_n;
    rd_addr = 27'h40; rd_len = 8'd7; rd_req = 1'b1;
    prev_en = 1'b0; prev_addr = '0; hold_bad = 0;
    for (int k = 0; k < 40; k++) begin
      rdy_used = (k % 2 == 0);
      app_rdy = rdy_used;
      tick();
      if (rd_gnt) rd_req = 1'b0;
      if (prev_en && !rdy_used && app_addr !== prev_addr) hold_bad++;
      prev_en = app_en; prev_addr = app_addr;
    end
    app_rdy = 1'b1;
    tick();
    chk("t3_ncmd", 64'(cmd_addr_q.size() - base_cmd), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_cmd%0d", i), cmd_word(base_cmd + i), {32'd0, 2'd0, 3'd1, 27'(27'h40 + 8 * i)});
    chk("t3_addr_hold", 64'(hold_bad), 64'd0);
    chk("t3_ngnt", 64'(rdgnt_n - base_rg), 64'd1);

    // Test 4: outstanding read limit blocks a third 32-beat read
    do_reset();
    base_rg = rdgnt_n;
    rd_addr = 27'h1000; rd_len = 8'd31; rd_req = 1'b1;
    repeat (80) tick();
    chk("t4_two_reads", 64'(rdgnt_n - base_rg), 64'd2);
    chk("t4_blocked_en", {63'd0, app_en}, 64'd0);
    wr_addr = 27'h700; wr_len = 8'd0; wr_dvalid = 1'b1; wr_req = 1'b1;
    wait_gnt(1'b0, 10, "t4_wr_gnt");
    wr_req = 1'b0;
    repeat (4) tick();
    wr_dvalid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = '0;
      app_rd_data[31:0] = 32'(i) + 32'h55;
      #1;
      if (i == 0) chk("t4_rd_pass", {31'd0, rd_dvalid, rd_data[31:0]}, {31'd0, 1'b1, 32'h55});
      tick();
      if (i == 30) chk("t4_still_blocked", 64'(rdgnt_n - base_rg), 64'd2);
    end
    app_rd_data_valid = 1'b0;
    n = 0;
    while ((rdgnt_n - base_rg) < 3 && n < 10) begin tick(); n++; end
    chk("t4_unblocked", 64'(rdgnt_n - base_rg), 64'd3);
    rd_req = 1'b0;
    repeat (40) tick();
    chk("t4_no_err", {63'd0, rd_err}, 64'd0);

    // Read data with nothing outstanding sets a sticky error
    do_reset();
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    tick();
    chk("err_set", {63'd0, rd_err}, 64'd1);
    repeat (3) tick();
    chk("err_sticky", {63'd0, rd_err}, 64'd1);

    // Test 5: write data lags commands by 10 cycles
    do_reset();
    base_done = done_n;
    wr_addr = 27'h500; wr_len = 8'd3; wr_dvalid = 1'b0; wr_req = 1'b1;
    wait_gnt(1'b0, 10, "t5_gnt");
    wr_req = 1'b0;
    repeat (14) tick();
    chk("t5_wr_data_state", {62'd0, app_en, wr_dready}, 64'b01);
    chk("t5_no_done_yet", 64'(done_n - base_done), 64'd0);
    for (int b = 0; b < 4; b++) begin
      wr_dvalid = 1'b1;
      wr_data = '0; wr_data[7:0] = 8'(b);
      #1;
      chk($sformatf("t5_done_b%0d", b), {63'd0, wr_done}, {63'd0, (b == 3)});
      tick();
    end
    wr_dvalid = 1'b0;
    tick();
    chk("t5_done_cnt", 64'(done_n - base_done), 64'd1);
    chk("t5_idle_dready", {63'd0, wr_dready}, 64'd0);

    // Test 6: reset in the middle of a write command phase
    do_reset();
    base_done = done_n;
    wr_addr = 27'h800; wr_len = 8'd7; wr_dvalid = 1'b0; wr_req = 1'b1;
    wait_gnt(1'b0, 10, "t6_gnt");
    wr_req = 1'b0;
    base_wg = wrgnt_n + 1;
    repeat (2) tick();
    chk("t6_mid_en", {63'd0, app_en}, 64'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_cmd", {33'd0, app_en, app_cmd, app_addr}, {33'd0, 1'b0, 3'd7, 27'd0});
    rst = 1'b0; init_calib_complete = 1'b0; wr_req = 1'b1; wr_dvalid = 1'b1;
    repeat (5) tick();
    chk("t6_nop_wait", 64'(wrgnt_n - base_wg), 64'd0);
    chk("t6_no_done", 64'(done_n - base_done), 64'd0);
    init_calib_complete = 1'b1;
    wait_gnt(1'b0, 10, "t6_regnt");
    chk("t6_regnt_addr", {37'd0, app_addr}, {37'd0, 27'h800});
    wr_req = 1'b0;
    repeat (14) tick();
    wr_dvalid = 1'b0;
    chk("t6_done_after", 64'(done_n - base_done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
